// File: rtl/auto_permute_pipe_pkg.sv
// Shared types and helpers for the automorphism lane-permutation pipeline.
// The typedefs describe the default build (E=8, DATA_W=64); parameterised
// modules size their own local copies from the same layout.
package fhe_alu_pkg;
  localparam int FHE_DATA_W = 64;
  localparam int FHE_E      = 8;
  localparam int FHE_LOG_E  = $clog2(FHE_E);

  typedef logic [FHE_E-1:0][FHE_DATA_W-1:0] lane_vec_t;
  typedef logic [FHE_E-1:0][FHE_LOG_E:0]    tag_vec_t;

  // Per-beat sideband; p sits in the LSBs so the skip field has a fixed offset.
  typedef struct packed {
    logic                  last;
    logic [FHE_LOG_E:0]    skip;
    logic                  neg_en;
    logic [FHE_DATA_W-1:0] p;
  } beat_sb_t;

  function automatic int sb_width(int data_w, int log_e);
    return data_w + log_e + 3;
  endfunction

  function automatic int sb_skip_lsb(int data_w);
    return data_w + 1;
  endfunction
endpackage

// File: rtl/auto_permute_pipe_bfly.sv
// One registered self-routing butterfly column. Lane i swaps with lane
// i^(1<<STAGE) when its tag bit disagrees with its own index bit, unless
// the beat asks to bypass this stage. Tags always travel with their data.
module auto_bfly_stage
  import fhe_alu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int E      = 8,
  parameter int LOG_E  = $clog2(E),
  parameter int STAGE  = 0
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 adv,
  input  logic                                 in_vld,
  input  logic [E*DATA_W-1:0]                  in_data,
  input  logic [E*(LOG_E+1)-1:0]               in_tag,
  input  logic [sb_width(DATA_W, LOG_E)-1:0]   in_sb,
  output logic                                 out_vld,
  output logic [E*DATA_W-1:0]                  out_data,
  output logic [E*(LOG_E+1)-1:0]               out_tag,
  output logic [sb_width(DATA_W, LOG_E)-1:0]   out_sb
);
  localparam int TW       = LOG_E + 1;
  localparam int BIT      = 1 << STAGE;
  localparam int SKIP_LSB = sb_skip_lsb(DATA_W);

  typedef logic [E-1:0][DATA_W-1:0] lane_t;
  typedef logic [E-1:0][LOG_E:0]    tag_t;

  lane_t         d_in, d_nxt;
  tag_t          t_in, t_nxt;
  logic [LOG_E:0] skip;
  logic          bypass;

  assign d_in   = in_data;
  assign t_in   = in_tag;
  assign skip   = in_sb[SKIP_LSB +: TW];
  assign bypass = TW'(STAGE) < skip;

  // Swap network: each lane decides from its own tag only.
  always_comb begin
    d_nxt = d_in;
    t_nxt = t_in;
    for (int i = 0; i < E; i++) begin
      if (!bypass && (t_in[i][STAGE] != ((i & BIT) != 0))) begin
        d_nxt[i] = d_in[i ^ BIT];
        t_nxt[i] = t_in[i ^ BIT];
      end
    end
  end

  // Column register; everything holds under a global stall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_tag  <= '0;
      out_sb   <= '0;
    end else if (adv) begin
      out_vld  <= in_vld;
      out_data <= d_nxt;
      out_tag  <= t_nxt;
      out_sb   <= in_sb;
    end
  end
endmodule

// File: rtl/auto_permute_pipe.sv
// Back-pressurable lane permutation for the automorphism datapath:
// tag stage -> LOG_E butterfly columns -> conditional negate stage.
// A single global advance signal stalls every register together.
module auto_permute_pipe
  import fhe_alu_pkg::*;
#(
  parameter int DATA_W = FHE_DATA_W,
  parameter int E      = FHE_E,
  parameter int LOG_E  = $clog2(E)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [E*DATA_W-1:0] in_data,
  input  logic                in_last,
  input  logic [DATA_W-1:0]   in_k,
  input  logic [LOG_E:0]      in_ctrl_offset,
  input  logic [LOG_E:0]      in_skip,
  input  logic                in_neg_en,
  input  logic [DATA_W-1:0]   in_p,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [E*DATA_W-1:0] out_data,
  output logic                out_last
);
  localparam int TW   = LOG_E + 1;
  localparam int SB_W = sb_width(DATA_W, LOG_E);

  typedef logic [E-1:0][DATA_W-1:0] lane_t;
  typedef logic [E-1:0][LOG_E:0]    tag_t;
  typedef struct packed {
    logic              last;
    logic [LOG_E:0]    skip;
    logic              neg_en;
    logic [DATA_W-1:0] p;
  } sb_t;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Index 0 is the tag stage, index j+1 the output of butterfly column j.
  logic            vld_pipe  [LOG_E:0];
  lane_t           data_pipe [LOG_E:0];
  tag_t            tag_pipe  [LOG_E:0];
  logic [SB_W-1:0] sb_pipe   [LOG_E:0];

  logic [LOG_E:0] k_lo;
  tag_t           tag_nxt;
  logic           c_vld;
  lane_t          c_data;
  tag_t           c_tag;
  sb_t            c_sb;

  assign k_lo = in_k[LOG_E:0];

  // Tags in LOG_E+1 bits: the wrap at 2E is the natural truncation.
  always_comb begin
    tag_nxt = '0;
    for (int i = 0; i < E; i++) tag_nxt[i] = k_lo * TW'(i) + in_ctrl_offset;
  end

  // Tag stage register, capturing data and sideband alongside the tags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c_vld  <= 1'b0;
      c_data <= '0;
      c_tag  <= '0;
      c_sb   <= '0;
    end else if (adv) begin
      c_vld  <= in_valid;
      c_data <= in_data;
      c_tag  <= tag_nxt;
      c_sb   <= {in_last, in_skip, in_neg_en, in_p};
    end
  end

  assign vld_pipe[0]  = c_vld;
  assign data_pipe[0] = c_data;
  assign tag_pipe[0]  = c_tag;
  assign sb_pipe[0]   = c_sb;

  for (genvar j = 0; j < LOG_E; j++) begin : g_bfly
    auto_bfly_stage #(.DATA_W(DATA_W), .E(E), .LOG_E(LOG_E), .STAGE(j)) u_stage (
      .clk      (clk),
      .rstn     (rstn),
      .adv      (adv),
      .in_vld   (vld_pipe[j]),
      .in_data  (data_pipe[j]),
      .in_tag   (tag_pipe[j]),
      .in_sb    (sb_pipe[j]),
      .out_vld  (vld_pipe[j+1]),
      .out_data (data_pipe[j+1]),
      .out_tag  (tag_pipe[j+1]),
      .out_sb   (sb_pipe[j+1])
    );
  end

  sb_t   n_sb;
  lane_t neg_nxt;
  logic  unused_bits;

  assign n_sb        = sb_t'(sb_pipe[LOG_E]);
  assign unused_bits = ^{in_k[DATA_W-1:TW], n_sb.skip, tag_pipe[LOG_E]};

  // Negate lanes whose tag lands in the upper half; zero stays zero.
  always_comb begin
    neg_nxt = data_pipe[LOG_E];
    for (int i = 0; i < E; i++) begin
      if (n_sb.neg_en && tag_pipe[LOG_E][i][LOG_E] && (data_pipe[LOG_E][i] != '0))
        neg_nxt[i] = n_sb.p - data_pipe[LOG_E][i];
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= vld_pipe[LOG_E];
      out_last  <= n_sb.last;
      out_data  <= neg_nxt;
    end
  end
endmodule

// File: tb/tb_auto_permute_pipe.sv
// Directed + randomised bench for auto_permute_pipe (E=8, DATA_W=64).
// Expected beats are queued on acceptance and checked as they leave.
module tb_auto_permute_pipe;
  import fhe_alu_pkg::*;

  localparam int DW    = 64;
  localparam int E     = 8;
  localparam int LOG_E = 3;
  localparam int LAT   = LOG_E + 2;
  localparam logic [63:0] P = 64'hFFFF_FFFF_0000_0001;

  typedef struct {
    lane_vec_t data;
    logic      last;
  } exp_t;

  logic            clk = 1'b0;
  logic            rstn;
  logic            in_valid, in_ready, in_last, in_neg_en;
  logic [E*DW-1:0] in_data;
  logic [DW-1:0]   in_k, in_p;
  logic [LOG_E:0]  in_ctrl_offset, in_skip;
  logic            out_valid, out_ready, out_last;
  logic [E*DW-1:0] out_data;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  bit   rnd_ready = 1'b0;

  always #5 clk = ~clk;

  auto_permute_pipe #(.DATA_W(DW), .E(E), .LOG_E(LOG_E)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .in_k           (in_k),
    .in_ctrl_offset (in_ctrl_offset),
    .in_skip        (in_skip),
    .in_neg_en      (in_neg_en),
    .in_p           (in_p),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last)
  );

  task automatic check(input string tag, input logic [E*DW-1:0] obs, input logic [E*DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Destination-based reference: with XOR-structured tags, bits below skip keep
  // the source index and the rest come from the tag; tag MSB selects negation.
  function automatic lane_vec_t model(input lane_vec_t d, input logic [63:0] k,
                                      input logic [3:0] off, input logic [3:0] skip,
                                      input logic neg, input logic [63:0] p);
    lane_vec_t  r;
    logic [3:0] t;
    int         mask, dest;
    r    = '0;
    mask = (skip >= 4'(LOG_E)) ? E - 1 : (1 << skip) - 1;
    for (int i = 0; i < E; i++) begin
      t    = k[3:0] * 4'(i) + off;
      dest = (i & mask) | (int'(t[2:0]) & ~mask & (E - 1));
      r[dest] = (neg && t[3] && d[i] != '0) ? p - d[i] : d[i];
    end
    return r;
  endfunction

  task automatic set_ready();
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    set_ready();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input lane_vec_t d, input logic last, input logic [63:0] k,
                      input logic [3:0] off, input logic [3:0] skip, input logic neg,
                      input lane_vec_t exp);
    bit acc;
    acc = 1'b0;
    for (int g = 0; g < 200 && !acc; g++) begin
      @(negedge clk);
      set_ready();
      in_valid = 1'b1; in_data = d; in_last = last; in_k = k;
      in_ctrl_offset = off; in_skip = skip; in_neg_en = neg; in_p = P;
      #4;
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    n_assert++;
    assert (acc) else begin
      n_fail++;
      $error("FAIL accept_timeout observed=%0d expected=1", acc);
    end
    if (acc) sb_q.push_back('{data: exp, last: last});
    in_valid = 1'b0;
  endtask

  task automatic wait_latency(input string tag);
    int cyc;
    cyc = 1;
    while (!out_valid && cyc < 30) begin
      idle();
      cyc++;
    end
    check(tag, E*DW'(cyc), E*DW'(LAT));
  endtask

  task automatic drain();
    for (int g = 0; g < 400 && (sb_q.size() != 0 || out_valid); g++) idle();
    check("drain_empty", E*DW'(sb_q.size()), '0);
  endtask

  // Output monitor, just before each rising edge.
  always begin
    @(negedge clk);
    #4;
    if (rstn === 1'b1) begin
      check("in_ready_adv", {511'b0, in_ready}, {511'b0, (!out_valid || out_ready)});
      if (out_valid) begin
        n_assert++;
        assert (sb_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_beat observed=%h expected=none", out_data);
        end
        if (sb_q.size() != 0) begin
          check("out_data", out_data, sb_q[0].data);
          check("out_last", {511'b0, out_last}, {511'b0, sb_q[0].last});
          if (out_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    lane_vec_t d, e;
    logic [63:0] k;
    logic [3:0]  off, skip;
    logic        neg;
    int          sel;

    rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_k = '0;
    in_ctrl_offset = '0; in_skip = '0; in_neg_en = 1'b0; in_p = P; out_ready = 1'b1;
    #12;
    check("rst_out_valid", {511'b0, out_valid}, '0);
    check("rst_out_last",  {511'b0, out_last},  '0);
    check("rst_out_data",  out_data, '0);
    check("rst_in_ready",  {511'b0, in_ready}, {511'b0, 1'b1});
    @(negedge clk);
    rstn = 1'b1;

    // 1: identity (upper k bits ignored), latency check
    for (int i = 0; i < E; i++) d[i] = 64'(i + 1);
    send(d, 1'b0, 64'hDEAD_BEEF_0000_0011, 4'd0, 4'd0, 1'b1, d);
    wait_latency("latency_t1");
    drain();

    // 2: reversal, no negation
    for (int i = 0; i < E; i++) e[i] = 64'(8 - i);
    send(d, 1'b0, 64'd15, 4'd7, 4'd0, 1'b1, e);
    drain();

    // 3: reversal with negation (zero kept), then negate disabled
    for (int i = 0; i < E; i++) d[i] = 64'(i);
    for (int i = 0; i < E; i++) e[i] = (i == 7) ? 64'd0 : P - 64'(7 - i);
    send(d, 1'b0, 64'd15, 4'd15, 4'd0, 1'b1, e);
    for (int i = 0; i < E; i++) e[i] = 64'(7 - i);
    send(d, 1'b1, 64'd15, 4'd15, 4'd0, 1'b0, e);
    drain();

    // 4: full bypass, back-to-back, last on beat 5
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < E; i++) d[i] = {$urandom, $urandom};
      send(d, (b == 4), 64'd15, 4'd7, 4'd3, 1'b1, d);
    end
    drain();

    // 5: random configs under random back-pressure
    rnd_ready = 1'b1;
    for (int b = 0; b < 20; b++) begin
      for (int i = 0; i < E; i++) d[i] = {$urandom, $urandom};
      sel  = $urandom_range(0, 3);
      k    = {$urandom, $urandom};
      k[3:0] = (sel == 0) ? 4'd1 : (sel == 1) ? 4'd7 : (sel == 2) ? 4'd9 : 4'd15;
      off  = ((k[2:0] == 3'd1) ? 4'd0 : 4'd7) + (($urandom_range(0, 1) != 0) ? 4'd8 : 4'd0);
      skip = 4'($urandom_range(0, 4));
      neg  = 1'($urandom_range(0, 1));
      send(d, 1'($urandom_range(0, 1)), k, off, skip, neg, model(d, k, off, skip, neg, P));
    end
    rnd_ready = 1'b0;
    drain();

    // 6: reset with beats in flight
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < E; i++) d[i] = 64'(b * 16 + i);
      send(d, 1'b0, 64'd1, 4'd0, 4'd0, 1'b0, d);
    end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst6_out_valid", {511'b0, out_valid}, '0);
    check("rst6_out_data",  out_data, '0);
    check("rst6_in_ready",  {511'b0, in_ready}, {511'b0, 1'b1});
    sb_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < E; i++) d[i] = 64'(100 + i);
    send(d, 1'b1, 64'd1, 4'd0, 4'd0, 1'b0, d);
    wait_latency("latency_t6");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
